matmul_apb_master: RTL and testbench
====================================

MATMUL_APB_MASTER -- requirements
Module: matmul_apb_master

Interface
REQ-001 BUS_WIDTH, 32, APB data width; DATA_WIDTH, 8, element width; MAX_DIM = BUS_WIDTH/DATA_WIDTH sets strobe width.
REQ-002 ADDR_WIDTH, 16, APB address width.
REQ-003 CMD_DEPTH, 4, command FIFO entries, power of two, >= 2.
REQ-004 TIMEOUT_CYC, 16, maximum ACCESS cycles before abort, >= 1.
REQ-005 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_i  input  1  synchronous, active-high reset.
REQ-007 cmd_valid_i  input  1  command offered.
REQ-008 cmd_ready_o  output  1  FIFO can accept a command; equals not-full.
REQ-009 cmd_write_i  input  1  1 = APB write, 0 = APB read.
REQ-010 cmd_addr_i  input  ADDR_WIDTH  target register address.
REQ-011 cmd_wdata_i  input  BUS_WIDTH  write data.
REQ-012 cmd_strb_i  input  MAX_DIM  write byte strobes.
REQ-013 rsp_valid_o  output  1  response held, stable until accepted.
REQ-014 rsp_ready_i  input  1  consumer accepts the response.
REQ-015 rsp_rdata_o  output  BUS_WIDTH  read data; 0 for writes and errors.
REQ-016 rsp_err_o  output  1  pslverr or timeout occurred.
REQ-017 psel_o, penable_o, pwrite_o  output  1 each  APB control to the matmul slave.
REQ-018 paddr_o  output  ADDR_WIDTH  APB address.
REQ-019 pwdata_o  output  BUS_WIDTH  APB write data.
REQ-020 pstrb_o  output  MAX_DIM  APB strobes.
REQ-021 pready_i, pslverr_i  input  1 each  slave completion and error.
REQ-022 prdata_i  input  BUS_WIDTH  slave read data.

Function
REQ-023 A command is pushed when cmd_valid_i and cmd_ready_o are both high; FIFO order is preserved, and a push while full never occurs.
REQ-024 FSM states are IDLE, SETUP, ACCESS, RESP; IDLE->SETUP when the FIFO is non-empty, popping the head into the transfer registers.
REQ-025 SETUP: psel_o=1, penable_o=0 for exactly one cycle, then go to ACCESS.
REQ-026 ACCESS: psel_o=1, penable_o=1; paddr/pwrite/pwdata/pstrb stay stable through SETUP and ACCESS.
REQ-027 ACCESS with pready_i=1: capture prdata_i (reads only) and pslverr_i, deassert psel/penable next cycle, go to RESP.
REQ-028 ACCESS with pready_i=0 for TIMEOUT_CYC consecutive cycles: abort, deassert psel/penable, rsp_err_o=1, rsp_rdata_o=0, go to RESP.
REQ-029 RESP: rsp_valid_o=1 until rsp_ready_i=1; the accepting cycle returns to IDLE, or goes directly to SETUP if the FIFO is non-empty.
REQ-030 Reads drive pstrb_o=0 and pwdata_o=0; an erroring read returns rsp_rdata_o=0.
REQ-031 Latency: a command pushed in cycle N into an empty FIFO in IDLE gives SETUP in N+1, ACCESS in N+2, and rsp_valid_o in N+3 when pready_i is high in N+2.
REQ-032 A push and a pop in the same cycle leave the occupancy unchanged; pointers wrap modulo CMD_DEPTH.
REQ-033 psel_o and penable_o are 0 outside SETUP and ACCESS; no back-to-back transfer skips SETUP.

Reset
REQ-034 While rst_i is high, the FSM goes to IDLE, the FIFO is flushed, cmd_ready_o=1, and all other outputs are 0 on the next edge.
REQ-035 A reset during ACCESS drops psel_o and penable_o on the next edge with no response; the in-flight command is discarded.

Structure
REQ-036 Package matmul_pkg holds the apb_mst_state_t enum, the cmd struct (write, addr, wdata, strb), and the default parameter constants.
REQ-037 The command FIFO is a separate sub-module, matmul_cmd_fifo, parameterised by CMD_DEPTH and the cmd struct.

Verification
REQ-038 Write addr=0x0004, data=0xA1B2C3D4, strb=0xF, pready tied 1 -> SETUP in N+1, ACCESS in N+2, rsp_valid in N+3 with err=0, rdata=0.
REQ-039 Read addr=0x0010, slave pready after 3 wait cycles, prdata=0x12345678 -> paddr stable throughout, pstrb=0, rsp_rdata=0x12345678.
REQ-040 Push 5 commands with CMD_DEPTH=4 and the slave stalled -> cmd_ready_o low after 4 accepted (head popped to transfer, so 5th accepted only after pop), all 5 completed in order.
REQ-041 pready held 0 -> abort after exactly 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, next queued command proceeds.
REQ-042 pslverr=1 on a read, then rsp_ready held 0 for 4 cycles, then rst_i asserted during the next ACCESS -> err=1 response held stable for 4 cycles; after reset, psel=0, FIFO empty, rsp_valid=0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and default constants for the matmul APB command master.
package matmul_pkg;

    localparam int BUS_WIDTH       = 32;
    localparam int DATA_WIDTH      = 8;
    localparam int MAX_DIM         = BUS_WIDTH / DATA_WIDTH;
    localparam int ADDR_WIDTH      = 16;
    localparam int DEF_CMD_DEPTH   = 4;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_mst_state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BUS_WIDTH-1:0]  wdata;
        logic [MAX_DIM-1:0]    strb;
    } cmd_t;

    // Reads never carry data or strobes onto the bus.
    function automatic cmd_t sanitize_cmd(input cmd_t c);
        cmd_t r;
        r = c;
        if (!c.write) begin
            r.wdata = '0;
            r.strb  = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/matmul_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module matmul_cmd_fifo
    import matmul_pkg::*;
#(
    parameter int  DEPTH = DEF_CMD_DEPTH,
    parameter type T     = cmd_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    // Pointer and occupancy tracking; simultaneous push and pop keep the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/matmul_apb_master.sv
// APB master that drains a command FIFO into single APB transfers to the matmul slave.
module matmul_apb_master
    import matmul_pkg::*;
#(
    parameter int CMD_DEPTH   = DEF_CMD_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [MAX_DIM-1:0]    cmd_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [MAX_DIM-1:0]    pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    apb_mst_state_t       r_state, w_state_nxt;
    cmd_t                 r_cmd;
    cmd_t                 w_cmd_in;
    cmd_t                 w_fifo_head;
    logic [TW-1:0]        r_wait_cnt;
    logic [BUS_WIDTH-1:0] r_rsp_rdata;
    logic                 r_rsp_err;

    logic w_full, w_empty;
    logic w_push, w_bypass, w_fifo_push;
    logic w_pop, w_load, w_capture, w_timeout, w_in_xfer;

    assign w_cmd_in = '{write: cmd_write_i, addr: cmd_addr_i,
                        wdata: cmd_wdata_i, strb: cmd_strb_i};

    assign cmd_ready_o = ~w_full;
    assign w_push      = cmd_valid_i & cmd_ready_o;
    // An idle master with nothing queued takes the command straight into the
    // transfer registers so SETUP follows the push by one cycle.
    assign w_bypass    = (r_state == ST_IDLE) & w_empty & w_push;
    assign w_fifo_push = w_push & ~w_bypass;

    matmul_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .T     (cmd_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_fifo_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and transfer control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_SETUP;
                end else if (w_bypass) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (pready_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Transfer registers, ACCESS wait counter and response capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cmd       <= '0;
            r_wait_cnt  <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_load) r_cmd <= sanitize_cmd(w_pop ? w_fifo_head : w_cmd_in);
            if (r_state == ST_SETUP)       r_wait_cnt <= '0;
            else if (r_state == ST_ACCESS) r_wait_cnt <= r_wait_cnt + TW'(1);
            if (w_capture) begin
                r_rsp_rdata <= (!r_cmd.write && !pslverr_i) ? prdata_i : '0;
                r_rsp_err   <= pslverr_i;
            end else if (w_timeout) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    // Bus outputs are forced low outside a transfer so idle/reset is all-zero.
    assign w_in_xfer   = (r_state == ST_SETUP) | (r_state == ST_ACCESS);
    assign psel_o      = w_in_xfer;
    assign penable_o   = (r_state == ST_ACCESS);
    assign pwrite_o    = w_in_xfer & r_cmd.write;
    assign paddr_o     = w_in_xfer ? r_cmd.addr  : '0;
    assign pwdata_o    = w_in_xfer ? r_cmd.wdata : '0;
    assign pstrb_o     = w_in_xfer ? r_cmd.strb  : '0;
    assign rsp_valid_o = (r_state == ST_RESP);
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed bench for matmul_apb_master with a hand-driven APB slave.
module tb_matmul_apb_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [15:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_strb_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [15:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i, pslverr_i;
    logic [31:0] prdata_i;

    logic        slv_echo;
    logic [31:0] slv_prdata;
    int          n_cmp = 0;
    int          n_err = 0;
    int          acc_cnt;

    // Echo mode returns an address-tagged word so ordering is visible.
    assign prdata_i = slv_echo ? {16'hC0DE, paddr_o} : slv_prdata;

    always #5 clk_i = ~clk_i;

    matmul_apb_master dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .cmd_strb_i  (cmd_strb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .pstrb_o     (pstrb_o),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i),
        .prdata_i    (prdata_i)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        cmd_strb_i  = s;
    endtask

    task automatic wait_rsp();
        int i;
        i = 0;
        while (!rsp_valid_o && i < 40) begin
            step();
            i++;
        end
        chk("rsp_wait", 64'(rsp_valid_o), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
        cmd_wdata_i = '0; cmd_strb_i = '0; rsp_ready_i = 1'b0; pready_i = 1'b0;
        pslverr_i = 1'b0; slv_echo = 1'b0; slv_prdata = '0;

        // Reset state
        repeat (3) step();
        chk("rst_psel",  64'(psel_o),      64'd0);
        chk("rst_pen",   64'(penable_o),   64'd0);
        chk("rst_rspv",  64'(rsp_valid_o), 64'd0);
        chk("rst_ready", 64'(cmd_ready_o), 64'd1);
        chk("rst_paddr", 64'(paddr_o),     64'd0);
        chk("rst_err",   64'(rsp_err_o),   64'd0);
        rst_i = 1'b0;
        step();

        // Write with zero-wait slave: SETUP N+1, ACCESS N+2, response N+3
        pready_i = 1'b1; slv_prdata = 32'hDEADBEEF;
        push(1'b1, 16'h0004, 32'hA1B2C3D4, 4'hF);
        chk("t1_ready", 64'(cmd_ready_o), 64'd1);
        step(); cmd_valid_i = 1'b0;
        chk("t1_setup_psel", 64'(psel_o),    64'd1);
        chk("t1_setup_pen",  64'(penable_o), 64'd0);
        chk("t1_paddr",      64'(paddr_o),   64'h0004);
        chk("t1_pwrite",     64'(pwrite_o),  64'd1);
        chk("t1_pwdata",     64'(pwdata_o),  64'hA1B2C3D4);
        chk("t1_pstrb",      64'(pstrb_o),   64'hF);
        step();
        chk("t1_acc_psel", 64'(psel_o),    64'd1);
        chk("t1_acc_pen",  64'(penable_o), 64'd1);
        chk("t1_acc_addr", 64'(paddr_o),   64'h0004);
        step();
        chk("t1_rspv",  64'(rsp_valid_o), 64'd1);
        chk("t1_err",   64'(rsp_err_o),   64'd0);
        chk("t1_rdata", 64'(rsp_rdata_o), 64'd0);
        chk("t1_psel0", 64'(psel_o),      64'd0);
        rsp_ready_i = 1'b1; step(); rsp_ready_i = 1'b0;
        chk("t1_rspv0", 64'(rsp_valid_o), 64'd0);

        // Read with three wait cycles
        pready_i = 1'b0; slv_prdata = 32'h12345678;
        push(1'b0, 16'h0010, 32'hFFFFFFFF, 4'hF);
        step(); cmd_valid_i = 1'b0;
        chk("t2_paddr",  64'(paddr_o),  64'h0010);
        chk("t2_pstrb",  64'(pstrb_o),  64'd0);
        chk("t2_pwdata", 64'(pwdata_o), 64'd0);
        chk("t2_pwrite", 64'(pwrite_o), 64'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t2_wait_pen",  64'(penable_o), 64'd1);
            chk("t2_wait_addr", 64'(paddr_o),   64'h0010);
            step();
        end
        pready_i = 1'b1;
        chk("t2_last_addr", 64'(paddr_o), 64'h0010);
        step();
        chk("t2_rspv",  64'(rsp_valid_o), 64'd1);
        chk("t2_rdata", 64'(rsp_rdata_o), 64'h12345678);
        chk("t2_err",   64'(rsp_err_o),   64'd0);
        chk("t2_psel0", 64'(psel_o),      64'd0);
        pready_i = 1'b0; rsp_ready_i = 1'b1; step(); rsp_ready_i = 1'b0;

        // Five commands against a stalled slave: one in flight plus four queued
        slv_echo = 1'b1;
        push(1'b0, 16'h0020, 32'h0, 4'h0);
        step(); cmd_valid_i = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            push(1'b0, 16'(16'h0024 + 4 * k), 32'h0, 4'h0);
            chk("t3_accept", 64'(cmd_ready_o), 64'd1);
            step();
        end
        cmd_valid_i = 1'b0;
        chk("t3_full",  64'(cmd_ready_o), 64'd0);
        chk("t3_stall", 64'(penable_o),   64'd1);
        chk("t3_haddr", 64'(paddr_o),     64'h0020);
        pready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp();
            chk("t3_order", 64'(rsp_rdata_o), 64'(32'hC0DE0020 + 4 * k));
            chk("t3_err",   64'(rsp_err_o),   64'd0);
            rsp_ready_i = 1'b1; step(); rsp_ready_i = 1'b0;
            if (k == 0) chk("t3_ready_again", 64'(cmd_ready_o), 64'd1);
            if (k < 4) begin
                chk("t3_direct_setup_psel", 64'(psel_o),    64'd1);
                chk("t3_direct_setup_pen",  64'(penable_o), 64'd0);
            end
        end
        pready_i = 1'b0;

        // Timeout after 16 ACCESS cycles, then the queued read proceeds
        push(1'b1, 16'h0040, 32'h00000055, 4'h3);
        step();
        push(1'b0, 16'h0044, 32'h0, 4'h0);
        step(); cmd_valid_i = 1'b0;
        acc_cnt = 0;
        while (penable_o && acc_cnt < 40) begin
            acc_cnt++;
            step();
        end
        chk("t4_access_cycles", 64'(acc_cnt), 64'd16);
        chk("t4_rspv",  64'(rsp_valid_o), 64'd1);
        chk("t4_err",   64'(rsp_err_o),   64'd1);
        chk("t4_rdata", 64'(rsp_rdata_o), 64'd0);
        chk("t4_psel0", 64'(psel_o),      64'd0);
        pready_i = 1'b1; rsp_ready_i = 1'b1; step(); rsp_ready_i = 1'b0;
        chk("t4_next_psel", 64'(psel_o),    64'd1);
        chk("t4_next_pen",  64'(penable_o), 64'd0);
        chk("t4_next_addr", 64'(paddr_o),   64'h0044);
        wait_rsp();
        chk("t4_next_rdata", 64'(rsp_rdata_o), 64'hC0DE0044);
        chk("t4_next_err",   64'(rsp_err_o),   64'd0);
        rsp_ready_i = 1'b1; step(); rsp_ready_i = 1'b0;

        // Slave error on a read, held response, then reset during ACCESS
        pslverr_i = 1'b1;
        push(1'b0, 16'h0050, 32'h0, 4'h0);
        step();
        push(1'b0, 16'h0054, 32'h0, 4'h0);
        step(); cmd_valid_i = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t5_hold_rspv",  64'(rsp_valid_o), 64'd1);
            chk("t5_hold_err",   64'(rsp_err_o),   64'd1);
            chk("t5_hold_rdata", 64'(rsp_rdata_o), 64'd0);
            step();
        end
        pslverr_i = 1'b0; pready_i = 1'b0; rsp_ready_i = 1'b1;
        step(); rsp_ready_i = 1'b0;
        chk("t5_r2_psel", 64'(psel_o),  64'd1);
        chk("t5_r2_addr", 64'(paddr_o), 64'h0054);
        push(1'b0, 16'h0058, 32'h0, 4'h0);
        step(); cmd_valid_i = 1'b0;
        chk("t5_r2_pen", 64'(penable_o), 64'd1);
        rst_i = 1'b1;
        step();
        chk("t5_rst_psel",  64'(psel_o),      64'd0);
        chk("t5_rst_pen",   64'(penable_o),   64'd0);
        chk("t5_rst_rspv",  64'(rsp_valid_o), 64'd0);
        chk("t5_rst_ready", 64'(cmd_ready_o), 64'd1);
        rst_i = 1'b0;
        repeat (3) step();
        chk("t5_flushed_psel", 64'(psel_o),      64'd0);
        chk("t5_flushed_rspv", 64'(rsp_valid_o), 64'd0);
        chk("t5_flushed_rdy",  64'(cmd_ready_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
